emb_line_fetch: RTL and testbench
=================================

# emb_line_fetch

Line-fetch sequencer sitting directly upstream of the 2048×32 synchronous embedded lookup memory (11-bit address, one-cycle read latency). On a start pulse it walks a contiguous address window forward or in reverse (horizontal mirror for the 1080p reversed-video path), drives the memory address/enable, captures returned 32-bit words and presents them as a valid/ready stream with an end-of-line marker. A 2-entry skid buffer absorbs downstream back-pressure without losing in-flight reads.

## Interface
- ADDR_W, 11, memory address width (window wraps modulo 2^ADDR_W)
- DATA_W, 32, memory/stream word width
- clk  in  1  sole clock, all logic rising-edge
- reset  in  1  synchronous, active-low reset
- start  in  1  single-cycle request; sampled only in IDLE
- base_addr  in  ADDR_W  first address of window
- line_len  in  ADDR_W  word count, 1..2047; 0 = request ignored
- reverse  in  1  0: base..base+len-1; 1: base+len-1 down to base
- busy  out  1  high while a line is in progress
- mem_enb  out  1  memory read enable
- mem_addr  out  ADDR_W  memory address
- mem_data  in  DATA_W  memory read data, valid the cycle after mem_enb=1
- m_data  out  DATA_W  stream data
- m_valid  out  1  stream valid
- m_ready  in  1  downstream ready
- m_last  out  1  high with final word of line
- done  out  1  one-cycle pulse after final word accepted

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE: on start=1 and line_len≠0 latch base_addr, line_len, reverse; load address counter with base (forward) or base+len-1 mod 2048 (reverse); remaining-issue count = len; go RUN. start with line_len=0 or while not IDLE: ignored, no side effects.
- RUN: issue a read (mem_enb=1, mem_addr=counter) when issue count>0 and (fifo_cnt + inflight − pop) < 2, pop = m_valid & m_ready. Each issue: counter ±1 mod 2048, issue count −1. Last issue → DRAIN.
- inflight: 1-bit flag, set the cycle after an issue; mem_data written into skid FIFO that cycle.
- DRAIN: no issues; when last word popped → IDLE, done=1 next cycle.
- Skid FIFO: depth 2, in-order; m_data/m_valid from head. Never overflows by construction of issue rule.
- m_last = m_valid & head is word number len (tracked by separate output counter).
- mem_addr holds last value when mem_enb=0; mem_enb=0 outside RUN.
- Simultaneous push and pop: both occur, count unchanged.
- Reset (any state): state IDLE, FIFO emptied, inflight cleared, pending memory return discarded.

## Timing
- Reset values: busy=0, mem_enb=0, mem_addr=0, m_data=0, m_valid=0, m_last=0, done=0.
- start at cycle T → busy=1 and first mem_enb at T+1 → first m_valid at T+2.
- m_ready held high: one word/cycle, final word accepted at T+1+len, busy=0 and done=1 at T+2+len; new start accepted at T+2+len.
- m_ready low: at most 2 words buffered, issuing stalls same cycle; resumes with zero bubble after ready returns.
- m_valid never drops while m_ready=0 (data stable until accepted).

## Test plan
- Forward: base=0x010, len=4, reverse=0, m_ready=1, memory holds addr as data → mem_addr 0x010..0x013 at T+1..T+4; m_data 0x010..0x013 at T+2..T+5, m_last at T+5, done at T+6.
- Reverse wrap: base=0x7FE, len=4, reverse=1 → addresses 0x001,0x000,0x7FF,0x7FE; same order on stream, m_last with 0x7FE.
- Back-pressure: len=8, m_ready toggled 1,0,0,1 repeating → all 8 words delivered in order, no duplicates/drops, never >2 valid-pending, data stable while stalled.
- Full line: base=0, len=1920, reverse=1, m_ready=1 → 1920 words, first 0x77F, last 0x000, done at T+1922.
- Ignored requests: start with len=0, and start while busy → no mem_enb, no state change; in-progress line unaffected.
- Reset mid-line: assert reset at word 3 of 8 with m_ready=0 → next cycle all outputs at reset values; subsequent start (len=2) streams exactly 2 fresh words.

Source files
------------

// File: rtl/emb_line_fetch.sv
// emb_line_fetch
//   Line-fetch sequencer for a synchronous embedded lookup memory with a
//   one-cycle read latency. A start request walks a contiguous address window
//   either forward or in reverse. The window wraps modulo 2^ADDR_W. Returned
//   words are presented as a valid/ready stream with an end-of-line marker.
//
//   Handshake: a word moves when m_valid & m_ready are both high at a rising
//   edge. Once m_valid is raised, it and m_data hold steady until that word
//   is accepted.
//
//   Ports
//     clk, reset          clock; synchronous active-low reset
//     start               request pulse, only looked at while idle
//     base_addr, line_len first address and word count (len 0 = ignored)
//     reverse             0: base upward, 1: base+len-1 downward
//     busy                line in progress
//     mem_enb, mem_addr   memory read strobe / address
//     mem_data            memory read data, one cycle after mem_enb
//     m_data, m_valid,    output stream
//     m_ready, m_last
//     done                one-cycle pulse after the final word is accepted
module emb_line_fetch #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] line_len,
  input  logic              reverse,
  output logic              busy,
  output logic              mem_enb,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

  state_t            state, state_nx;
  logic [ADDR_W-1:0] addr_cnt;
  logic [ADDR_W-1:0] last_addr;
  logic [ADDR_W-1:0] len_r;
  logic [ADDR_W-1:0] issue_cnt;
  logic [ADDR_W-1:0] out_cnt;
  logic              rev_r;
  logic              inflight;
  logic [DATA_W-1:0] fifo0, fifo1;
  logic [1:0]        fifo_cnt;
  logic              pop, push, pop_fifo, issue, accept;
  logic              done_nx, done_r;
  logic [2:0]        occ_after;

  // The word returning from memory this cycle is visible on the stream
  // straight away when the FIFO is empty. It only lands in the FIFO if it is
  // not taken right now.
  assign m_valid  = (fifo_cnt != 2'd0) | inflight;
  assign m_data   = (fifo_cnt != 2'd0) ? fifo0 : (inflight ? mem_data : '0);
  assign pop      = m_valid & m_ready;
  assign pop_fifo = pop & (fifo_cnt != 2'd0);
  assign push     = inflight & ~(pop & (fifo_cnt == 2'd0));
  assign m_last   = m_valid & (out_cnt == len_r - ONE);

  // Words buffered or arriving, minus the one leaving this cycle. Issuing
  // only while this is below 2 bounds buffered + in-flight words to 2.
  assign occ_after = {1'b0, fifo_cnt} + {2'b00, inflight} - {2'b00, pop};

  assign accept   = (state == IDLE) & start & (line_len != '0);
  assign busy     = (state != IDLE);
  assign mem_enb  = issue;
  assign mem_addr = issue ? addr_cnt : last_addr;
  assign done     = done_r;

  always_comb begin
    state_nx = state;
    issue    = 1'b0;
    done_nx  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_nx = RUN;
      end
      RUN: begin
        if ((issue_cnt != '0) && (occ_after < 3'd2)) begin
          issue = 1'b1;
          if (issue_cnt == ONE) state_nx = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && m_last) begin
          state_nx = IDLE;
          done_nx  = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      addr_cnt  <= '0;
      last_addr <= '0;
      len_r     <= '0;
      issue_cnt <= '0;
      out_cnt   <= '0;
      rev_r     <= 1'b0;
      inflight  <= 1'b0;
      fifo0     <= '0;
      fifo1     <= '0;
      fifo_cnt  <= 2'd0;
      done_r    <= 1'b0;
    end else begin
      state    <= state_nx;
      done_r   <= done_nx;
      inflight <= issue;

      if (accept) begin
        len_r     <= line_len;
        rev_r     <= reverse;
        issue_cnt <= line_len;
        out_cnt   <= '0;
        addr_cnt  <= reverse ? (base_addr + line_len - ONE) : base_addr;
      end

      if (issue) begin
        last_addr <= addr_cnt;
        addr_cnt  <= rev_r ? (addr_cnt - ONE) : (addr_cnt + ONE);
        issue_cnt <= issue_cnt - ONE;
      end

      if (pop) out_cnt <= out_cnt + ONE;

      // A push into a full FIFO cannot happen: an in-flight word implies at
      // most one word already buffered.
      case ({push, pop_fifo})
        2'b10: begin
          if (fifo_cnt == 2'd0) fifo0 <= mem_data;
          else                  fifo1 <= mem_data;
          fifo_cnt <= fifo_cnt + 2'd1;
        end
        2'b01: begin
          fifo0    <= fifo1;
          fifo_cnt <= fifo_cnt - 2'd1;
        end
        2'b11: begin
          if (fifo_cnt == 2'd1) begin
            fifo0 <= mem_data;
          end else begin
            fifo0 <= fifo1;
            fifo1 <= mem_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_emb_line_fetch.sv
// Bench for emb_line_fetch: a line table applied in a loop plus hand-written
// reset, ignored-request and reset-mid-line sequences. Memory returns its own
// address as data.
module tb_emb_line_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [10:0] base_addr;
  logic [10:0] line_len;
  logic        reverse;
  logic        busy;
  logic        mem_enb;
  logic [10:0] mem_addr;
  logic [31:0] mem_data = '0;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic        m_last;
  logic        done;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] exp_q[$];

  typedef struct {
    logic [10:0] base;
    logic [10:0] len;
    logic        rev;
    int          mode;   // 0: m_ready high, 1: m_ready 1,0,0,1 repeating
    logic        poke;   // fire a second start mid-line
    logic [31:0] first;
    logic [31:0] last;
  } line_t;

  line_t tbl[8];

  emb_line_fetch #(.ADDR_W(11), .DATA_W(32)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .line_len(line_len), .reverse(reverse), .busy(busy), .mem_enb(mem_enb),
    .mem_addr(mem_addr), .mem_data(mem_data), .m_data(m_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last), .done(done)
  );

  // clock / memory model
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_enb) mem_data <= {21'h0, mem_addr};
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "watchdog");
  end

  // driver / checker tasks
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},     32'(busy),     32'h0);
    check({tag, "_mem_enb"},  32'(mem_enb),  32'h0);
    check({tag, "_mem_addr"}, 32'(mem_addr), 32'h0);
    check({tag, "_m_data"},   m_data,        32'h0);
    check({tag, "_m_valid"},  32'(m_valid),  32'h0);
    check({tag, "_m_last"},   32'(m_last),   32'h0);
    check({tag, "_done"},     32'(done),     32'h0);
  endtask

  // Starts the line in the current cycle and runs it to the done pulse.
  task automatic run_line(input line_t v);
    int          issued, popped, done_cyc, budget;
    logic        prev_stall;
    logic [31:0] prev_data, first_w, last_w, exp_w;
    logic [10:0] a;
    exp_q.delete();
    for (int i = 0; i < int'(v.len); i++) begin
      a = v.rev ? (v.base + v.len - 11'd1 - 11'(i)) : (v.base + 11'(i));
      exp_q.push_back({21'h0, a});
    end
    issued = 0; popped = 0; done_cyc = -1; prev_stall = 1'b0;
    prev_data = '0; first_w = 'x; last_w = 'x;
    budget = 4 * int'(v.len) + 20;
    start = 1'b1; base_addr = v.base; line_len = v.len; reverse = v.rev; m_ready = 1'b1;
    for (int cyc = 1; cyc <= budget && done_cyc < 0; cyc++) begin
      tick();
      start = v.poke && (cyc == 3);
      if (v.poke) begin
        base_addr = 11'h300; line_len = 11'd2; reverse = 1'b1;
      end
      m_ready = (v.mode == 0) ? 1'b1 : (((cyc - 1) % 4 == 0) || ((cyc - 1) % 4 == 3));
      #1;
      if (cyc == 1) begin
        check("first_busy", 32'(busy), 32'h1);
        check("first_issue", 32'(mem_enb), 32'h1);
      end
      if (cyc == 2) check("first_valid", 32'(m_valid), 32'h1);
      if (prev_stall) begin
        check("stall_valid", 32'(m_valid), 32'h1);
        check("stall_data", m_data, prev_data);
      end
      if (mem_enb) begin
        a = v.rev ? (v.base + v.len - 11'd1 - 11'(issued)) : (v.base + 11'(issued));
        check("issue_addr", 32'(mem_addr), 32'(a));
        issued++;
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_word", m_data, 32'hDEAD_BEEF);
        end else begin
          exp_w = exp_q.pop_front();
          check("word", m_data, exp_w);
          check("last_flag", 32'(m_last), 32'(exp_q.size() == 0));
        end
        if (popped == 0) first_w = m_data;
        last_w = m_data;
        popped++;
      end
      check("occupancy", 32'((issued - popped) <= 2), 32'h1);
      prev_stall = m_valid & ~m_ready;
      prev_data  = m_data;
      if (done) begin
        done_cyc = cyc;
        check("done_busy", 32'(busy), 32'h0);
      end
    end
    start = 1'b0;
    if (done_cyc < 0) check("done_timeout", 32'h0, 32'h1);
    check("all_words", 32'(exp_q.size()), 32'h0);
    check("issue_count", 32'(issued), 32'(v.len));
    check("first_word", first_w, v.first);
    check("last_word", last_w, v.last);
    if (v.mode == 0) check("done_cycle", 32'(done_cyc), 32'(int'(v.len) + 2));
  endtask

  initial begin
    tbl[0] = '{11'h010, 11'd4,    1'b0, 0, 1'b0, 32'h010, 32'h013};
    tbl[1] = '{11'h7FE, 11'd4,    1'b1, 0, 1'b0, 32'h001, 32'h7FE};
    tbl[2] = '{11'h100, 11'd8,    1'b0, 1, 1'b0, 32'h100, 32'h107};
    tbl[3] = '{11'h000, 11'd1920, 1'b1, 0, 1'b0, 32'h77F, 32'h000};
    tbl[4] = '{11'h7FF, 11'd1,    1'b0, 0, 1'b0, 32'h7FF, 32'h7FF};
    tbl[5] = '{11'h7FD, 11'd5,    1'b0, 1, 1'b0, 32'h7FD, 32'h001};
    tbl[6] = '{11'h020, 11'd8,    1'b1, 1, 1'b0, 32'h027, 32'h020};
    tbl[7] = '{11'h200, 11'd6,    1'b0, 0, 1'b1, 32'h200, 32'h205};

    // clock / reset block
    reset = 1'b0; start = 1'b0; base_addr = '0; line_len = '0; reverse = 1'b0; m_ready = 1'b1;
    repeat (3) tick();
    #1;
    check_reset_outputs("reset");
    tick();
    reset = 1'b1;

    // start with zero length is ignored
    tick();
    start = 1'b1; base_addr = 11'h005; line_len = 11'd0;
    for (int c = 0; c < 4; c++) begin
      tick();
      start = 1'b0;
      #1;
      check("len0_busy", 32'(busy), 32'h0);
      check("len0_enb", 32'(mem_enb), 32'h0);
      check("len0_valid", 32'(m_valid), 32'h0);
    end

    // table lines, back to back: each new start lands in the done cycle
    for (int i = 0; i < 8; i++) run_line(tbl[i]);

    // reset mid-line with the stream stalled
    tick();
    start = 1'b1; base_addr = 11'h040; line_len = 11'd8; reverse = 1'b0; m_ready = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      tick();
      start = 1'b0;
      #1;
      if (c == 4) check("stalled_valid", 32'(m_valid), 32'h1);
    end
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    check_reset_outputs("midreset");
    run_line('{11'h050, 11'd2, 1'b0, 0, 1'b0, 32'h050, 32'h051});
    for (int c = 0; c < 3; c++) begin
      tick();
      #1;
      check("post_valid", 32'(m_valid), 32'h0);
      check("post_enb", 32'(mem_enb), 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
